reg_bank_mp: RTL and testbench



---
 rtl/reg_bank_mp.sv | 102 ++++++++++
 tb/tb_reg_bank_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank: one clocked write port, NRD combinational read ports with write-first bypass.
// Reads are zero-latency. Writes commit at the next edge. A clr_req sweep clears one entry per cycle and drops writes while busy.
// Optional REG_BANK_ZERO_REG_EN: entry 0 reads as zero and ignores writes.
module reg_bank_mp #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    input  logic              clr_req,
    output logic              busy
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          wr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    always_comb begin
        wr_ok = we && in_range(wa);
`ifdef REG_BANK_ZERO_REG_EN
        if (wa == '0) wr_ok = 1'b0;
`endif
    end

    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ok) mem_d[wa] = wd;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                // Writes and further clr_req are deliberately ignored until the sweep ends.
                mem_d[ptr_q] = '0;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy = (state_q == ST_CLEAR);

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] val;

        assign addr = ra[g*AW +: AW];

        always_comb begin
            val = '0;
            if (in_range(addr)) begin
                val = mem_q[addr];
                if ((state_q == ST_IDLE) && we && (wa == addr)) val = wd;
            end
`ifdef REG_BANK_ZERO_REG_EN
            if (addr == '0) val = '0;
`endif
        end

        assign rd[g*DW +: DW] = val;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: a 32-entry instance and a 24-entry instance for out-of-range checks.
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_reg_bank_mp;

    localparam bit ZR =
`ifdef REG_BANK_ZERO_REG_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, clr_req;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        busy;

    logic        s_we, s_clr;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic [9:0]  s_ra;
    logic [63:0] s_rd;
    logic        s_busy;

    always #5 clk = ~clk;

    reg_bank_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra(ra), .rd(rd), .clr_req(clr_req), .busy(busy)
    );

    reg_bank_mp #(.DW(32), .DEPTH(24), .AW(5), .NRD(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .we(s_we), .wa(s_wa), .wd(s_wd),
        .ra(s_ra), .rd(s_rd), .clr_req(s_clr), .busy(s_busy)
    );

    string       nm_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m [32];

    task automatic push(input string nm, input int sel, input logic [31:0] v);
        nm_q.push_back(nm);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ev);
        n_vec++;
        if (act !== ev) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r0, input logic [4:0] r1);
        we = w;
        wa = a;
        wd = d;
        ra = {r1, r0};
    endtask

    function automatic logic [31:0] mrd(input int a);
        if (a >= 32) return 32'h0;
        if (ZR && a == 0) return 32'h0;
        return m[a];
    endfunction

    task automatic mwr(input int a, input logic [31:0] d);
        if (!(ZR && a == 0)) m[a] = d;
    endtask

    always @(negedge clk) begin
        while (nm_q.size() > 0) begin
            string       nm;
            int          sel;
            logic [31:0] ev, act;
            nm  = nm_q.pop_front();
            sel = sel_q.pop_front();
            ev  = exp_q.pop_front();
            case (sel)
                0:       act = rd[31:0];
                1:       act = rd[63:32];
                2:       act = {31'b0, busy};
                3:       act = s_rd[31:0];
                4:       act = s_rd[63:32];
                default: act = {31'b0, s_busy};
            endcase
            n_vec++;
            if (act !== ev) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", nm, act, ev);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        rst_n = 1'b0; clr_req = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        s_we = 1'b0; s_clr = 1'b0; s_wa = 5'd0; s_wd = 32'h0; s_ra = 10'd0;

        // T1: reset clears everything
        step();
        rst_n = 1'b1;
        chk("t1_busy_reset", {31'b0, busy}, 32'h0);
        for (int a = 0; a < 32; a += 2) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1));
            s_ra = {5'(a + 1), 5'(a)};
            push("t1_rd0", 0, 32'h0);
            push("t1_rd1", 1, 32'h0);
            push("t1_busy", 2, 32'h0);
            if (a < 24) push("t1_s_rd0", 3, 32'h0);
            step();
        end

        // T2: same-cycle bypass on both ports, then stored value
        drive(1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3);
        push("t2_byp0", 0, 32'hDEAD_BEEF);
        push("t2_byp1", 1, 32'hDEAD_BEEF);
        step(); mwr(3, 32'hDEAD_BEEF);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        push("t2_hold0", 0, 32'hDEAD_BEEF);
        push("t2_hold1", 1, 32'hDEAD_BEEF);
        step();
        drive(1'b1, 5'd4, 32'h0000_1234, 5'd4, 5'd3);
        push("t2_byp_mix0", 0, 32'h0000_1234);
        push("t2_byp_mix1", 1, 32'hDEAD_BEEF);
        step(); mwr(4, 32'h0000_1234);

        // T3: fill, sweep, dropped write during sweep
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(100 + i), 5'd3, 5'd31);
            step(); mwr(i, 32'(100 + i));
        end
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        push("t3_fill5", 0, 32'd105);
        push("t3_fill31", 1, 32'd131);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        push("t3_fill0", 0, ZR ? 32'd0 : 32'd100);
        push("t3_fill1", 1, 32'd101);
        clr_req = 1'b1;
        push("t3_busy_pre", 2, 32'h0);
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k == 2) drive(1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd1);
            else        drive(1'b0, 5'd0, 32'h0, 5'd5, (k == 0) ? 5'd0 : 5'(k - 1));
            push("t3_busy", 2, 32'h1);
            push("t3_rd5", 0, mrd(5));
            if (k > 0) push("t3_swept", 1, 32'h0);
            step(); m[k] = 32'h0;
        end
        chk("t3_wait_expired", {31'b0, busy}, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        push("t3_busy_done", 2, 32'h0);
        push("t3_drop5", 0, 32'h0);
        push("t3_clr31", 1, 32'h0);
        step();
        for (int a = 0; a < 32; a += 4) begin
            drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 3));
            push("t3_clr_a", 0, 32'h0);
            push("t3_clr_b", 1, 32'h0);
            step();
        end

        // T4: reset in the middle of a sweep
        drive(1'b1, 5'd2, 32'd22, 5'd0, 5'd0);  step(); mwr(2, 32'd22);
        drive(1'b1, 5'd20, 32'd200, 5'd0, 5'd0); step(); mwr(20, 32'd200);
        drive(1'b0, 5'd0, 32'h0, 5'd20, 5'd2);
        push("t4_pre20", 0, 32'd200);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(); m[k] = 32'h0;
        end
        rst_n = 1'b0;
        push("t4_busy_at10", 2, 32'h1);
        push("t4_pre_rst20", 0, 32'd200);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        chk("t4_busy_after_rst", {31'b0, busy}, 32'h0);
        chk("t4_rd20_after_rst", rd[31:0], 32'h0);
        push("t4_busy_rst", 2, 32'h0);
        push("t4_rd20", 0, 32'h0);
        push("t4_rd2", 1, 32'h0);
        step();
        drive(1'b1, 5'd7, 32'h77, 5'd7, 5'd20);
        push("t4_byp7", 0, 32'h77);
        push("t4_rd20b", 1, 32'h0);
        step(); mwr(7, 32'h77);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        push("t4_hold7", 0, 32'h77);
        push("t4_idle", 2, 32'h0);
        step();

        // T5: out-of-range on the 24-entry bank
        s_we = 1'b1; s_wa = 5'd23; s_wd = 32'd5;
        step();
        s_wa = 5'd30; s_wd = 32'd1; s_ra = {5'd23, 5'd30};
        push("t5_oor_rd", 3, 32'h0);
        push("t5_rd23", 4, 32'd5);
        step();
        s_we = 1'b0;
        s_ra = {5'd14, 5'd6};
        push("t5_alias6", 3, 32'h0);
        push("t5_alias14", 4, 32'h0);
        step();
        s_ra = {5'd23, 5'd24};
        push("t5_rd24", 3, 32'h0);
        push("t5_rd23b", 4, 32'd5);
        push("t5_busy", 5, 32'h0);
        step();

        // T6: entry 0 behaviour depends on the zero-register build option
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd7);
        push("t6_byp0", 0, ZR ? 32'h0 : 32'hFFFF_FFFF);
        push("t6_rd7", 1, 32'h77);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        push("t6_hold0", 0, ZR ? 32'h0 : 32'hFFFF_FFFF);
        push("t6_hold0b", 1, ZR ? 32'h0 : 32'hFFFF_FFFF);
        step();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
